// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// fills the IF/ID pipeline register, honouring stall and branch/jump redirects.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        pc_oob_o
);

    localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);
    localparam logic [31:0] RESET_PC_AL  = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] br_target_al;
    logic        pc_oob;

    assign pc_plus4     = pc_q + 32'd4;
    assign jump_target  = {pc4_q[31:28], jump_index_i, 2'b00};
    assign br_target_al = {br_target_i[31:2], 2'b00};
    assign pc_oob       = {2'b00, pc_q[31:2]} >= IMEM_WORDS_W;

    // NOTE: every next-state signal is defaulted to its held value first so no
    // path through this block can leave one unassigned and infer a latch.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (jump_i || br_taken_i) begin
            // Redirect squashes the wrong-path fetch; jump has priority.
            pc_d    = jump_i ? jump_target : br_target_al;
            valid_d = 1'b0;
            instr_d = NOP_WORD;
        end else if (!stall_i) begin
            pc_d  = pc_plus4;
            pc4_d = pc_plus4;
            if (pc_oob) begin
                valid_d = 1'b0;
                instr_d = NOP_WORD;
            end else begin
                valid_d = 1'b1;
                instr_d = imem_data_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC_AL;
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign if_id_valid_o = valid_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc4_o   = pc4_q;
    assign pc_oob_o      = pc_oob;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed vector table, reset-during-
// redirect sequence, then random stimulus against a behavioural model.
module tb_mips_fetch_stage;

    localparam int          WORDS = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br_taken, jump;
    logic [31:0] br_target;
    logic [25:0] jump_index;
    logic [31:0] imem_addr, imem_data, pc, if_id_instr, if_id_pc4;
    logic        if_id_valid, pc_oob;

    logic [31:0] mem [WORDS];

    always #5 clk = ~clk;

    mips_fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .NOP_WORD(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .jump_i       (jump),
        .jump_index_i (jump_index),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .pc_o         (pc),
        .if_id_valid_o(if_id_valid),
        .if_id_instr_o(if_id_instr),
        .if_id_pc4_o  (if_id_pc4),
        .pc_oob_o     (pc_oob)
    );

    // Out-of-range reads return garbage so a design that forwards them is caught.
    assign imem_data = (imem_addr < 32'(4 * WORDS)) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
        br_target = 32'h0; jump_index = 26'h0;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] br_target;
        logic        jump;
        logic [25:0] jidx;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        chk_pc4;
        logic        e_oob;
    } vec_t;

    vec_t vecs[16];

    // Behavioural reference state for the random phase.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h0000_8020;
        mem[1] = 32'h2011_0028;

        //           stall br  br_target      jmp jidx      pc            v  instr          pc4           c  oob
        vecs[0]  = '{1'b0,1'b0,32'h0,        1'b0,26'h0,  32'h4,        1,32'h0000_8020,32'h4,        1, 0};
        vecs[1]  = '{1'b0,1'b0,32'h0,        1'b0,26'h0,  32'h8,        1,32'h2011_0028,32'h8,        1, 0};
        vecs[2]  = '{1'b0,1'b0,32'h0,        1'b0,26'h0,  32'hC,        1,32'hA000_0002,32'hC,        1, 0};
        vecs[3]  = '{1'b0,1'b0,32'h0,        1'b1,26'h6,  32'h18,       0,NOP,          32'h0,        0, 0};
        vecs[4]  = '{1'b0,1'b0,32'h0,        1'b0,26'h0,  32'h1C,       1,32'hA000_0006,32'h1C,       1, 0};
        vecs[5]  = '{1'b0,1'b0,32'h0,        1'b0,26'h0,  32'h20,       1,32'hA000_0007,32'h20,       1, 0};
        vecs[6]  = '{1'b1,1'b1,32'h2E,       1'b0,26'h0,  32'h2C,       0,NOP,          32'h0,        0, 0};
        vecs[7]  = '{1'b1,1'b0,32'h0,        1'b0,26'h0,  32'h2C,       0,NOP,          32'h0,        0, 0};
        vecs[8]  = '{1'b1,1'b0,32'h0,        1'b0,26'h0,  32'h2C,       0,NOP,          32'h0,        0, 0};
        vecs[9]  = '{1'b0,1'b0,32'h0,        1'b0,26'h0,  32'h30,       1,32'hA000_000B,32'h30,       1, 0};
        vecs[10] = '{1'b0,1'b1,32'hFFC,      1'b0,26'h0,  32'hFFC,      0,NOP,          32'h0,        0, 0};
        vecs[11] = '{1'b0,1'b0,32'h0,        1'b0,26'h0,  32'h1000,     1,32'hA000_03FF,32'h1000,     1, 1};
        vecs[12] = '{1'b0,1'b0,32'h0,        1'b0,26'h0,  32'h1004,     0,NOP,          32'h1004,     1, 1};
        vecs[13] = '{1'b0,1'b1,32'hFFFF_FFFC,1'b0,26'h0,  32'hFFFF_FFFC,0,NOP,          32'h0,        0, 1};
        vecs[14] = '{1'b0,1'b0,32'h0,        1'b0,26'h0,  32'h0,        0,NOP,          32'h0,        1, 0};
        vecs[15] = '{1'b0,1'b1,32'h100,      1'b1,26'h10, 32'h40,       0,NOP,          32'h0,        0, 0};

        rst = 1'b1;
        idle_inputs();
        step();
        step();
        check("reset_pc", pc, 32'h0);
        check("reset_valid", {31'b0, if_id_valid}, 32'h0);
        check("reset_instr", if_id_instr, NOP);
        check("reset_pc4", if_id_pc4, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            stall      = vecs[i].stall;
            br_taken   = vecs[i].br;
            br_target  = vecs[i].br_target;
            jump       = vecs[i].jump;
            jump_index = vecs[i].jidx;
            step();
            check($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_pc);
            check($sformatf("vec%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].e_instr);
            if (vecs[i].chk_pc4) check($sformatf("vec%0d_pc4", i), if_id_pc4, vecs[i].e_pc4);
            check($sformatf("vec%0d_oob", i), {31'b0, pc_oob}, {31'b0, vecs[i].e_oob});
        end
        idle_inputs();

        // Reset arriving together with a redirect and a stall discards both.
        step();
        rst = 1'b1; jump = 1'b1; jump_index = 26'h3FF; stall = 1'b1;
        step();
        check("rst_jump_pc", pc, 32'h0);
        check("rst_jump_valid", {31'b0, if_id_valid}, 32'h0);
        check("rst_jump_instr", if_id_instr, NOP);
        check("rst_jump_pc4", if_id_pc4, 32'h0);
        rst = 1'b0;
        idle_inputs();

        m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_pc4 = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic r;
            logic [31:0] t;
            r          = ($urandom_range(0, 99) < 2);
            stall      = ($urandom_range(0, 99) < 25);
            br_taken   = ($urandom_range(0, 99) < 10);
            jump       = ($urandom_range(0, 99) < 8);
            br_target  = ($urandom_range(0, 9) < 7) ? 32'($urandom_range(0, 4300)) : $urandom();
            jump_index = ($urandom_range(0, 9) < 8) ? 26'($urandom_range(0, 1100)) : 26'($urandom());
            rst        = r;

            if (r) begin
                m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_pc4 = 32'h0;
            end else if (jump || br_taken) begin
                t = jump ? {m_pc4[31:28], jump_index, 2'b00} : (br_target & 32'hFFFF_FFFC);
                m_pc = t; m_valid = 1'b0; m_instr = NOP;
            end else if (!stall) begin
                if (m_pc / 4 < WORDS) begin
                    m_valid = 1'b1; m_instr = mem[m_pc / 4];
                end else begin
                    m_valid = 1'b0; m_instr = NOP;
                end
                m_pc  = m_pc + 32'd4;
                m_pc4 = m_pc;
            end

            step();
            check("rand_pc", pc, m_pc);
            check("rand_addr", imem_addr, m_pc);
            check("rand_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            check("rand_instr", if_id_instr, m_instr);
            check("rand_pc4", if_id_pc4, m_pc4);
            check("rand_oob", {31'b0, pc_oob}, {31'b0, (m_pc / 4 >= WORDS)});
        end
        rst = 1'b0;
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline; directly upstream of the instruction memory.
- Owns the PC and drives the instruction-memory word address combinationally.
- Captures the returned instruction word into the IF/ID pipeline register for decode.
- Accepts stall and redirect (branch/jump) requests from decode; no branch delay slot: a redirect squashes the in-flight fetch.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; PCs at or beyond 4*IMEM_WORDS are out of range.
- NOP_WORD, 32'h00000000, instruction inserted into IF/ID for bubbles.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents (decode/hazard unit).
- br_taken  in  1  branch resolved taken in ID this cycle.
- br_target  in  32  full branch target byte address.
- jump  in  1  J-type jump in ID this cycle.
- jump_index  in  26  instr_index field of the jump.
- imem_addr  out  32  byte address to instruction memory (= pc).
- imem_data  in  32  instruction word returned combinationally by instruction memory.
- pc  out  32  current fetch PC.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  fetched instruction word.
- if_id_pc4  out  32  address of fetched instruction + 4.
- pc_oob  out  1  current pc out of range (combinational).

Behaviour:
- Reset (rst=1 at edge, regardless of other inputs):
  - pc <= RESET_PC.
  - if_id_valid <= 0, if_id_instr <= NOP_WORD, if_id_pc4 <= 0.
  - Reset mid-stall or mid-redirect discards that request.
- Address path:
  - imem_addr = pc (combinational, 0-cycle).
  - Instruction for pc is registered into IF/ID at the next edge; one-cycle fetch latency.
- Jump target = {if_id_pc4[31:28], jump_index, 2'b00}.
- Branch target: br_target with bits [1:0] forced to 00.
- Per-edge priority (rst not asserted):
  1. Redirect (jump or br_taken):
     - pc <= target; jump wins if both are asserted.
     - if_id_valid <= 0, if_id_instr <= NOP_WORD (squash the wrong-path fetch).
     - Overrides stall.
  2. Stall:
     - pc and all IF/ID outputs hold.
  3. Normal:
     - pc <= pc + 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
     - if_id_instr <= imem_data, if_id_pc4 <= pc + 4, if_id_valid <= 1.
- Out of range:
  - pc_oob = ((pc >> 2) >= IMEM_WORDS).
  - While pc_oob=1, normal advance loads NOP_WORD with if_id_valid <= 0; imem_data is ignored (may be X).
  - pc still increments; a later redirect recovers.
- pc[1:0] is always 00; no misaligned PC is ever produced.
- No other state; outputs change only at clk edges except imem_addr and pc_oob.

Test Plan:
- Reset, then 3 free cycles; memory word0=0x00008020, word1=0x20110028 -> after first edge imem_addr=0x4, if_id_instr=0x00008020, if_id_pc4=0x4, valid=1; next edge instr=0x20110028, pc4=0x8.
- Jump: jump=1, jump_index=26'h6, if_id_pc4=0x28 -> next pc=0x18, if_id_valid=0, if_id_instr=0; following edge fetches word6 with pc4=0x1C.
- Branch plus stall: br_taken=1, br_target=0x2E, stall=1 at pc=0x20 -> pc=0x2C, bubble inserted; stall alone at pc=0x2C for 2 cycles -> pc and IF/ID unchanged.
- Out of range: IMEM_WORDS=1024, pc reaches 0xFFC then 0x1000 -> at pc=0x1000 pc_oob=1; next edge valid=0, instr=NOP_WORD, pc=0x1004.
- Wrap: drive br_target=0xFFFFFFFC, then one free cycle -> pc=0x00000000, if_id_pc4=0x00000000.
- Reset during redirect: rst=1 with jump=1 -> pc=RESET_PC, valid=0.
